apb_requester: RTL and testbench

//  APB initiator: converts a valid/ready command stream (single read/write) into APB SETUP/ACCESS

---
 rtl/apb_requester_pkg.sv | 15 +
 rtl/apb_requester_if.sv | 47 ++++
 rtl/apb_requester_timeout_ctr.sv | 27 ++
 rtl/apb_requester.sv | 124 ++++++++++++
 tb/tb_apb_requester.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_requester_pkg.sv
// Shared definitions for APB initiators: FSM state encoding and default sizing.
package apb_requester_pkg;

  localparam int DEFAULT_BUS_WIDTH      = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // Transfer phases of one APB command, 2-bit encoded.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/apb_requester_if.sv
// Command/response stream plus APB bus seen by an APB initiator.
// master = the initiator itself, slave = the environment around it
// (command source, response sink and APB completer).
interface apb_requester_if
  import apb_requester_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
);
  // command stream
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [BUS_WIDTH-1:0]   req_addr;
  logic [BUS_WIDTH-1:0]   req_wdata;
  logic [BUS_WIDTH/8-1:0] req_strb;
  // response stream
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [BUS_WIDTH-1:0]   rsp_rdata;
  logic                   rsp_err;
  logic                   rsp_timeout;
  // APB
  logic [BUS_WIDTH-1:0]   PADDR;
  logic [BUS_WIDTH-1:0]   PWDATA;
  logic [BUS_WIDTH/8-1:0] PSTRB;
  logic                   PSELx;
  logic                   PENABLE;
  logic                   PWRITE;
  logic                   PREADY;
  logic                   PSLVERR;
  logic [BUS_WIDTH-1:0]   PRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
           PREADY, PSLVERR, PRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PWDATA, PSTRB, PSELx, PENABLE, PWRITE
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
           PREADY, PSLVERR, PRDATA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PWDATA, PSTRB, PSELx, PENABLE, PWRITE
  );

endinterface

// File: rtl/apb_requester_timeout_ctr.sv
// Counts ACCESS wait cycles; expired flags the cycle that reaches limit-1.
// limit == 0 disables the timeout entirely.
module apb_requester_timeout_ctr #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_reg;

  assign expired = (limit != '0) && (count_reg == limit - CNT_W'(1));

  // Count enabled cycles, restart on clear, saturate once expired.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_requester.sv
// APB initiator: one valid/ready command in, one SETUP/ACCESS transfer out,
// one held response back. Single outstanding command.
module apb_requester
  import apb_requester_pkg::*;
#(
  parameter int BUS_WIDTH      = DEFAULT_BUS_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  apb_requester_if.master   bus
);

  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t               state_reg;
  logic [BUS_WIDTH-1:0] paddr_reg;
  logic [BUS_WIDTH-1:0] pwdata_reg;
  logic [STRB_W-1:0]    pstrb_reg;
  logic                 pwrite_reg;
  logic                 psel_reg;
  logic                 penable_reg;
  logic                 rsp_valid_reg;
  logic [BUS_WIDTH-1:0] rsp_rdata_reg;
  logic                 rsp_err_reg;
  logic                 rsp_timeout_reg;

  logic ctr_clear;
  logic ctr_enable;
  logic ctr_expired;

  // Counter restarts while in SETUP so the first ACCESS cycle sees zero.
  assign ctr_clear  = (state_reg == ST_SETUP);
  assign ctr_enable = (state_reg == ST_ACCESS) && !bus.PREADY;

  apb_requester_timeout_ctr #(
    .CNT_W (CNT_W)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .limit   (LIMIT),
    .expired (ctr_expired)
  );

  assign bus.req_ready   = (state_reg == ST_IDLE) && !reset;
  assign bus.PADDR       = paddr_reg;
  assign bus.PWDATA      = pwdata_reg;
  assign bus.PSTRB       = pstrb_reg;
  assign bus.PWRITE      = pwrite_reg;
  assign bus.PSELx       = psel_reg;
  assign bus.PENABLE     = penable_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;
  assign bus.rsp_err     = rsp_err_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;

  // Transfer sequencer with registered APB and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      pstrb_reg       <= '0;
      pwrite_reg      <= 1'b0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.req_valid) begin
            paddr_reg   <= bus.req_addr;
            pwdata_reg  <= bus.req_wdata;
            // reads never carry strobes on APB
            pstrb_reg   <= bus.req_write ? bus.req_strb : '0;
            pwrite_reg  <= bus.req_write;
            psel_reg    <= 1'b1;
            penable_reg <= 1'b0;
            state_reg   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PREADY in the final allowed cycle beats the timeout
          if (bus.PREADY) begin
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_err_reg     <= bus.PSLVERR;
            rsp_timeout_reg <= 1'b0;
            rsp_rdata_reg   <= (!pwrite_reg && !bus.PSLVERR) ? bus.PRDATA : '0;
            state_reg       <= ST_RESP;
          end else if (ctr_expired) begin
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_err_reg     <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            rsp_rdata_reg   <= '0;
            state_reg       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: directed + randomized commands against a
// transaction-timeline model; one line printed per transaction.
module tb_apb_requester;

  localparam int BW = 32;
  localparam int T  = 16;
  localparam int MAXTX = 64;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  apb_requester_if #(.BUS_WIDTH(BW)) bus ();

  apb_requester #(
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] prdata;
    int          waits;   // PREADY-low ACCESS cycles before PREADY
    bit          slverr;
    int          hold;    // rsp_ready-low cycles once response is up
    bit          eager;   // req_valid held high whenever this command is next
    int          rst_at;  // >0: pulse reset at this offset after accept
  } txn_t;

  txn_t txq[$];

  int          errors = 0;
  int          checks = 0;
  int          obs_lat   [MAXTX];
  int          obs_setup [MAXTX];
  logic [31:0] obs_rdata [MAXTX];
  logic        obs_err   [MAXTX];
  logic        obs_to    [MAXTX];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] s, input logic [31:0] rd, input int wt,
                     input bit se, input int hd, input bit eg, input int ra);
    txn_t t;
    t.write = w;  t.addr = a;   t.wdata = wd; t.strb = s;  t.prdata = rd;
    t.waits = wt; t.slverr = se; t.hold = hd; t.eager = eg; t.rst_at = ra;
    txq.push_back(t);
  endtask

  initial begin
    bit   busy;
    int   acc, k, cur_id, idx, finished, rst_left, c, d;
    bit   ph_setup, ph_acc, ph_rsp;
    bit   exp_to, exp_err;
    logic [31:0] exp_rdata;
    txn_t cur;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    bus.PRDATA    = '0;

    for (int i = 0; i < MAXTX; i++) begin
      obs_lat[i] = -1; obs_setup[i] = -1;
      obs_rdata[i] = '0; obs_err[i] = 1'b0; obs_to[i] = 1'b0;
    end

    // directed: 0 BAUD write, 1 read 3 waits, 2 PSLVERR, 3 timeout,
    // 4 long rsp hold, 5 last-chance PREADY, 6 reset mid-ACCESS, 7 after reset
    add(1'b1, 32'h4,  32'h0000_0A2C, 4'hF, 32'h0,         0,  1'b0, 0,  1'b1, 0);
    add(1'b0, 32'h8,  32'h1111_1111, 4'hF, 32'hDEAD_BEEF, 3,  1'b0, 0,  1'b1, 0);
    add(1'b0, 32'hC,  32'h0,         4'h1, 32'h1234_5678, 0,  1'b1, 0,  1'b1, 0);
    add(1'b0, 32'h10, 32'h0,         4'h1, 32'hCAFE_F00D, T,  1'b0, 1,  1'b1, 0);
    add(1'b1, 32'h0,  32'h0000_0041, 4'h1, 32'h0,         0,  1'b0, 10, 1'b1, 0);
    add(1'b0, 32'h5,  32'h0,         4'hF, 32'hA5A5_5A5A, 15, 1'b0, 0,  1'b1, 0);
    add(1'b0, 32'h8,  32'h0,         4'hF, 32'h7777_7777, 3,  1'b0, 0,  1'b1, 3);
    add(1'b1, 32'h3,  32'h0000_0003, 4'h2, 32'h0,         1,  1'b0, 0,  1'b1, 0);
    for (int i = 0; i < 40; i++) begin
      int r, wt;
      r = int'($urandom_range(0, 9));
      if (r < 6)      wt = int'($urandom_range(0, 3));
      else if (r < 8) wt = int'($urandom_range(4, 8));
      else            wt = int'($urandom_range(14, 18));
      add(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), $urandom,
          wt, ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_PSELx",       32'(bus.PSELx),       32'h0);
    chk("rst_PENABLE",     32'(bus.PENABLE),     32'h0);
    chk("rst_PWRITE",      32'(bus.PWRITE),      32'h0);
    chk("rst_PADDR",       bus.PADDR,            32'h0);
    chk("rst_PWDATA",      bus.PWDATA,           32'h0);
    chk("rst_PSTRB",       32'(bus.PSTRB),       32'h0);
    chk("rst_rsp_valid",   32'(bus.rsp_valid),   32'h0);
    chk("rst_rsp_rdata",   bus.rsp_rdata,        32'h0);
    chk("rst_rsp_err",     32'(bus.rsp_err),     32'h0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
    chk("rst_req_ready",   32'(bus.req_ready),   32'h0);

    busy = 1'b0; acc = 0; k = 0; cur_id = 0; idx = 0; finished = 0; rst_left = 0; c = 0;
    cur = txq[0];

    while (finished < txq.size() && c < 20000) begin
      d        = c - acc;
      ph_setup = busy && (d == 1);
      ph_acc   = busy && (d >= 2) && (d < 2 + k);
      ph_rsp   = busy && (d >= 2 + k);

      // compare against the timeline of the current transaction
      chk("req_ready", 32'(bus.req_ready), 32'(!busy && !reset));
      chk("PSELx",     32'(bus.PSELx),     32'(ph_setup || ph_acc));
      chk("PENABLE",   32'(bus.PENABLE),   32'(ph_acc));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(ph_rsp));
      if (ph_setup || ph_acc) begin
        chk("PADDR",  bus.PADDR,          cur.addr);
        chk("PWRITE", 32'(bus.PWRITE),    32'(cur.write));
        chk("PSTRB",  32'(bus.PSTRB),     32'(cur.write ? cur.strb : 4'h0));
        if (cur.write) chk("PWDATA", bus.PWDATA, cur.wdata);
      end
      if (ph_rsp) begin
        exp_to    = (cur.waits >= T);
        exp_err   = exp_to || cur.slverr;
        exp_rdata = (exp_to || cur.write || cur.slverr) ? 32'h0 : cur.prdata;
        chk("rsp_rdata",   bus.rsp_rdata,        exp_rdata);
        chk("rsp_err",     32'(bus.rsp_err),     32'(exp_err));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_to));
      end
      if (busy && bus.PSELx && !bus.PENABLE && obs_setup[cur_id] < 0) obs_setup[cur_id] = c;
      if (busy && bus.rsp_valid && obs_lat[cur_id] < 0) begin
        obs_lat[cur_id]   = d;
        obs_rdata[cur_id] = bus.rsp_rdata;
        obs_err[cur_id]   = bus.rsp_err;
        obs_to[cur_id]    = bus.rsp_timeout;
      end

      // drive inputs for this cycle
      if (rst_left > 0) begin
        reset = 1'b1; rst_left--;
      end else if (busy && cur.rst_at > 0 && d == cur.rst_at) begin
        reset = 1'b1; rst_left = 1;
      end else begin
        reset = 1'b0;
      end

      if (ph_acc && (d - 2) == cur.waits) begin
        bus.PREADY = 1'b1; bus.PSLVERR = cur.slverr; bus.PRDATA = cur.prdata;
      end else if (ph_acc) begin
        bus.PREADY = 1'b0; bus.PSLVERR = 1'($urandom_range(0, 1)); bus.PRDATA = $urandom;
      end else begin
        bus.PREADY = 1'($urandom_range(0, 1));
        bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA = $urandom;
      end

      if (ph_rsp) bus.rsp_ready = ((d - (2 + k)) >= cur.hold);
      else        bus.rsp_ready = 1'($urandom_range(0, 1));

      if (idx < txq.size() && (txq[idx].eager || $urandom_range(0, 2) != 0)) begin
        bus.req_valid = 1'b1;
        bus.req_write = txq[idx].write;
        bus.req_addr  = txq[idx].addr;
        bus.req_wdata = txq[idx].wdata;
        bus.req_strb  = txq[idx].strb;
      end else begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_strb  = 4'($urandom);
      end

      // advance the model across the coming edge
      if (reset) begin
        if (busy) begin
          $display("txn %0d dropped by reset at offset %0d", cur_id, d);
          finished++;
        end
        busy = 1'b0;
      end else if (ph_rsp && bus.rsp_ready) begin
        $display("txn %0d %s addr=%h latency=%0d rdata=%h err=%0b timeout=%0b",
                 cur_id, cur.write ? "WR" : "RD", cur.addr, obs_lat[cur_id],
                 obs_rdata[cur_id], obs_err[cur_id], obs_to[cur_id]);
        busy = 1'b0;
        finished++;
      end else if (!busy && bus.req_valid) begin
        cur_id = idx;
        cur    = txq[idx];
        idx++;
        busy   = 1'b1;
        acc    = c;
        k      = (cur.waits < T) ? cur.waits + 1 : T;
      end

      @(negedge clk);
      c++;
    end

    chk("all_txns_done", 32'(finished), 32'(txq.size()));

    // hand-computed expectations for the directed transactions
    chk("t1_latency",    32'(obs_lat[0]),   32'd3);
    chk("t1_rdata",      obs_rdata[0],      32'h0);
    chk("t1_err",        32'(obs_err[0]),   32'h0);
    chk("t2_latency",    32'(obs_lat[1]),   32'd6);
    chk("t2_rdata",      obs_rdata[1],      32'hDEAD_BEEF);
    chk("t3_err",        32'(obs_err[2]),   32'h1);
    chk("t3_timeout",    32'(obs_to[2]),    32'h0);
    chk("t3_rdata",      obs_rdata[2],      32'h0);
    chk("t4_latency",    32'(obs_lat[3]),   32'd18);
    chk("t4_err",        32'(obs_err[3]),   32'h1);
    chk("t4_timeout",    32'(obs_to[3]),    32'h1);
    chk("t5_spacing",    32'(obs_setup[5] - obs_setup[4]), 32'd14);
    chk("t5_lastchance", 32'(obs_lat[5]),   32'd18);
    chk("t5_no_timeout", 32'(obs_to[5]),    32'h0);
    chk("t6_no_rsp",     32'(obs_lat[6]),   32'hFFFF_FFFF);
    chk("t6_after_rst",  32'(obs_lat[7]),   32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
